add_arbiter: RTL
================

# add_arbiter

Two-requester round-robin arbiter in front of a single shared registered adder. Each requester presents an operand pair on a valid/ready port; the block grants one per cycle, pushes it through a two-stage pipeline (operand register, sum register), and returns the sum tagged with the requester ID on a valid/ready response port. It sits between the input-decode logic and the output mux of the top-level user project, replacing per-requester adders with one shared datapath.

## Interface
- `W`: default 4. Operand width; sum is `W+1` bits.
- `clk`: in, 1. Single clock, rising edge.
- `rst`: in, 1. Asynchronous, active-high reset.
- `req0_valid`: in, 1. Requester 0 has an operand pair.
- `req0_a`, `req0_b`: in, W each. Requester 0 operands.
- `req0_ready`: out, 1. Requester 0 accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: as above, for requester 1.
- `rsp_valid`: out, 1. Response holds a sum.
- `rsp_sum`: out, W+1. `a + b`, zero-extended, unsigned.
- `rsp_id`: out, 1. Requester that issued this sum.
- `rsp_ready`: in, 1. Consumer accepts the response.

## Operation
- Pipeline:
  - S1 holds `{v1, a1, b1, id1}`. S2 holds `{rsp_valid, rsp_sum, rsp_id}`.
  - `adv2 = !rsp_valid | rsp_ready`.
  - `adv1 = !v1 | adv2`. This is the accept enable.
- Arbitration:
  - Pointer `last` names the most recently granted ID.
  - Only one valid requester: grant it.
  - Both valid: grant `!last`.
  - Neither valid: no grant.
- Handshake:
  - `reqX_ready = adv1 & grant==X & reqX_valid`.
  - A transfer occurs on `valid & ready`.
  - `last` updates only on a transfer, never on an idle or stalled cycle.
- On transfer: S1 loads the operands and ID, and sets `v1=1`.
- If `adv1` is true and there is no transfer: `v1` clears.
- If `adv2` is true: S2 loads `{v1, a1+b1, id1}`. Otherwise S2 holds all fields.
- Arithmetic: unsigned, width `W+1`, no overflow possible. For W=4, maximum is 15+15 = 30.
- Backpressure: while `rsp_valid & !rsp_ready`:
  - S2 is frozen.
  - S1 is frozen if full.
  - An empty S1 still accepts one request, so at most 2 requests are in flight.
- Requester rule: once `reqX_valid` rises, it and its operands stay stable until `reqX_ready`. The block does not need to tolerate withdrawal.
- Reset (async assert, any time, including mid-stall):
  - `v1=0`, `a1=b1=0`, `id1=0`.
  - `rsp_valid=0`, `rsp_sum=0`, `rsp_id=0`.
  - `last=1`, so requester 0 wins the first tie.
  - In-flight data is discarded.

## Timing
- Latency: a transfer at edge N makes `rsp_valid=1` with the result after edge N+1. The response is visible 2 cycles after the request cycle.
- Throughput: 1 result/cycle with `rsp_ready` held high. Under continuous contention the grants alternate 0,1,0,1.
- Combinational paths:
  - `reqX_ready` depends on `req0_valid`, `req1_valid`, `rsp_ready` and internal state.
  - No path from `reqX_a`/`reqX_b` to any output.
- All registered outputs reset asynchronously. The ready outputs are combinational; they are 0 while `rst` is high because `rst` gates the grant.
- Simultaneous response pop and request accept with both stages full: legal, full throughput, no bubble.

## Structure
- Package `add_arb_pkg`:
  - `localparam int unsigned ADD_W = 4`.
  - `typedef logic id_t`.
  - `typedef struct packed {logic v; logic [ADD_W-1:0] a, b; id_t id;} s1_t`.
- Sub-module `rr_arb2`: 2-way round-robin grant.
  - Ports: `clk`, `rst`, `req[1:0]`, `take`, `gnt[1:0]`.
  - Holds `last`; updates it on `take`.
- Top module: pipeline registers and handshake logic only.

## Test plan
- Single request, idle output: `req0` (a=3, b=5), `rsp_ready=1`. Expect `req0_ready` the same cycle, and `rsp_valid`/`rsp_sum`=8/`rsp_id`=0 two cycles later for one cycle.
- Tie after reset: both valid, `req0` (15,15), `req1` (1,2). Expect `req0` granted first, then `req1`. Responses in order: 30/id0, then 3/id1.
- Sustained contention: both requesters always valid for 10 cycles, `rsp_ready=1`. Expect grants alternating 0,1,…; 10 responses, one per cycle, with no bubbles.
- Backpressure: hold `rsp_ready=0` with `req1` streaming.
  - Expect exactly 2 accepts, then `req1_ready=0`, and `rsp_sum` stable.
  - Raise `rsp_ready`: both results drain in order, and accepts resume the same cycle.
- Mid-operation reset: assert `rst` with both stages full and stalled.
  - Expect `rsp_valid=0`, `rsp_sum=0`, `rsp_id=0` immediately, and both ready outputs low.
  - After release, a tie grants `req0`.
- Exhaustive arithmetic: all 256 `(a,b)` pairs alternated across both ports. Check every `rsp_sum == a+b` (5-bit) with the correct `rsp_id`.

Source files
------------

// File: rtl/add_arb_pkg.sv
// Shared types and widths for the two-requester shared-adder arbiter.
package add_arb_pkg;

  localparam int unsigned ADD_W = 4;

  typedef logic id_t;

  typedef struct packed {
    logic             v;
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
    id_t              id;
  } s1_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer names the last requester that completed a transfer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
    last_d = last_q;
    if (take) last_d = gnt[1];
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding one shared two-stage adder pipeline (operand reg, sum reg)
// with valid/ready on both request ports and the tagged response port.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int unsigned W = ADD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic [W:0]   rsp_sum,
  output id_t          rsp_id,
  input  logic         rsp_ready
);

  logic         v1_q, v1_d;
  logic [W-1:0] a1_q, a1_d;
  logic [W-1:0] b1_q, b1_d;
  id_t          id1_q, id1_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [W:0]   rsp_sum_q, rsp_sum_d;
  id_t          rsp_id_q, rsp_id_d;

  logic [1:0]   gnt;
  logic         adv1, adv2, take;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({req1_valid, req0_valid}),
    .take (take),
    .gnt  (gnt)
  );

  always_comb begin
    adv2       = !rsp_valid_q | rsp_ready;
    adv1       = !v1_q | adv2;
    req0_ready = adv1 & gnt[0] & req0_valid;
    req1_ready = adv1 & gnt[1] & req1_valid;
    take       = req0_ready | req1_ready;

    v1_d        = v1_q;
    a1_d        = a1_q;
    b1_d        = b1_q;
    id1_d       = id1_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;

    if (take) begin
      v1_d  = 1'b1;
      id1_d = req1_ready;
      a1_d  = req1_ready ? req1_a : req0_a;
      b1_d  = req1_ready ? req1_b : req0_b;
    end else if (adv1) begin
      v1_d = 1'b0;
    end

    // S2 refills whenever its content is gone or being consumed this cycle.
    if (adv2) begin
      rsp_valid_d = v1_q;
      rsp_sum_d   = {1'b0, a1_q} + {1'b0, b1_q};
      rsp_id_d    = id1_q;
    end
  end

  // NOTE: reset is asynchronous and clears every pipeline field, so in-flight data is dropped the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      id1_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      id1_q       <= id1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

endmodule
